solve_controller: RTL and testbench

Sequencing controller that sits between the board's user inputs and the `grid` solver. It turns the raw active-high button levels into synchronized single-cycle events. It then runs each solve attempt as a clear → start → run sequence, watches the solver's done flags and enforces a cycle timeout. It also keeps the status registers that the top level shows on the HEX, LED and cursor monitors: result, elapsed cycles, occupancy view mode and latched cursor position.

---
 rtl/solve_controller.sv | 140 ++++++++++++++
 tb/tb_solve_controller.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/solve_controller.sv
// solve_controller: conditions the board buttons into single-cycle events,
// sequences each solve attempt as clear -> start -> run with a cycle timeout,
// and holds the result, elapsed-cycle, view-mode and cursor status registers.
module solve_controller #(
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
    parameter int unsigned CYCLE_W        = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start_req,
    input  logic               snap_req,
    input  logic               view_req,
    input  logic               grid_done_success,
    input  logic               grid_done_failure,
    input  logic [3:0]         grid_cursor_row,
    input  logic [3:0]         grid_cursor_col,
    output logic               grid_clear,
    output logic               grid_start,
    output logic               busy,
    output logic               done_success,
    output logic               done_failure,
    output logic               done_timeout,
    output logic [CYCLE_W-1:0] cycles,
    output logic [1:0]         view_mode,
    output logic [3:0]         cursor_row,
    output logic [3:0]         cursor_col
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_START,
        S_RUN,
        S_DONE_OK,
        S_DONE_FAIL,
        S_TIMEOUT
    } state_t;

    localparam logic [CYCLE_W-1:0] LAST_RUN_CYCLE = CYCLE_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CYCLE_W-1:0] TIMEOUT_VALUE  = CYCLE_W'(TIMEOUT_CYCLES);

    // bit 0 = s1, bit 1 = s2, bit 2 = s3
    logic [2:0]         start_sync_q, snap_sync_q, view_sync_q;
    logic               start_rise, snap_rise, view_rise;

    state_t             state_q, state_d;
    logic [CYCLE_W-1:0] cycles_q, cycles_d;
    logic               grid_clear_q, grid_start_q;
    logic [1:0]         view_q, view_d;
    logic [3:0]         row_q, col_q;

    // Three-flop synchronizers on the asynchronous button levels
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            start_sync_q <= '0;
            snap_sync_q  <= '0;
            view_sync_q  <= '0;
        end else begin
            start_sync_q <= {start_sync_q[1:0], start_req};
            snap_sync_q  <= {snap_sync_q[1:0], snap_req};
            view_sync_q  <= {view_sync_q[1:0], view_req};
        end
    end

    assign start_rise = start_sync_q[1] & ~start_sync_q[2];
    assign snap_rise  = snap_sync_q[1]  & ~snap_sync_q[2];
    assign view_rise  = view_sync_q[1]  & ~view_sync_q[2];

    // Attempt sequencing, done checks in priority order and cycle counting
    always_comb begin
        state_d  = state_q;
        cycles_d = cycles_q;
        unique case (state_q)
            S_IDLE, S_DONE_OK, S_DONE_FAIL, S_TIMEOUT: begin
                if (start_rise) state_d = S_CLEAR;
            end
            S_CLEAR: begin
                cycles_d = '0;
                state_d  = S_START;
            end
            S_START: begin
                state_d = S_RUN;
            end
            S_RUN: begin
                if (grid_done_success) begin
                    state_d = S_DONE_OK;
                end else if (grid_done_failure) begin
                    state_d = S_DONE_FAIL;
                end else if (cycles_q == LAST_RUN_CYCLE) begin
                    state_d  = S_TIMEOUT;
                    cycles_d = TIMEOUT_VALUE;
                end else begin
                    cycles_d = cycles_q + CYCLE_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // View mode steps 0 -> 1 -> 2 -> 0 on each view event
    always_comb begin
        view_d = view_q;
        if (view_rise) view_d = (view_q == 2'd2) ? 2'd0 : view_q + 2'd1;
    end

    // State, counter, pulse and status registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cycles_q     <= '0;
            grid_clear_q <= 1'b0;
            grid_start_q <= 1'b0;
            view_q       <= '0;
            row_q        <= '0;
            col_q        <= '0;
        end else begin
            state_q      <= state_d;
            cycles_q     <= cycles_d;
            grid_clear_q <= (state_d == S_CLEAR);
            grid_start_q <= (state_d == S_START);
            view_q       <= view_d;
            if (snap_rise) begin
                row_q <= grid_cursor_row;
                col_q <= grid_cursor_col;
            end
        end
    end

    assign grid_clear   = grid_clear_q;
    assign grid_start   = grid_start_q;
    assign busy         = (state_q == S_CLEAR) || (state_q == S_START) || (state_q == S_RUN);
    assign done_success = (state_q == S_DONE_OK);
    assign done_failure = (state_q == S_DONE_FAIL);
    assign done_timeout = (state_q == S_TIMEOUT);
    assign cycles       = cycles_q;
    assign view_mode    = view_q;
    assign cursor_row   = row_q;
    assign cursor_col   = col_q;

endmodule

// File: tb/tb_solve_controller.sv
// Self-checking bench for solve_controller with a small timeout so that the
// timeout path is reachable; expectations come from the attempt-level rules.
module tb_solve_controller;

    localparam int unsigned T  = 8;
    localparam int unsigned CW = 8;

    logic          clock = 1'b0;
    logic          reset;
    logic          start_req, snap_req, view_req;
    logic          gs, gf;
    logic [3:0]    gr, gc;
    logic          grid_clear, grid_start, busy;
    logic          done_success, done_failure, done_timeout;
    logic [CW-1:0] cycles;
    logic [1:0]    view_mode;
    logic [3:0]    cursor_row, cursor_col;

    int n_tests = 0;
    int n_fail  = 0;
    int clr_cnt = 0;
    int st_cnt  = 0;

    int       model_view;
    logic [3:0] model_row, model_col;

    solve_controller #(.TIMEOUT_CYCLES(T), .CYCLE_W(CW)) dut (
        .clock             (clock),
        .reset             (reset),
        .start_req         (start_req),
        .snap_req          (snap_req),
        .view_req          (view_req),
        .grid_done_success (gs),
        .grid_done_failure (gf),
        .grid_cursor_row   (gr),
        .grid_cursor_col   (gc),
        .grid_clear        (grid_clear),
        .grid_start        (grid_start),
        .busy              (busy),
        .done_success      (done_success),
        .done_failure      (done_failure),
        .done_timeout      (done_timeout),
        .cycles            (cycles),
        .view_mode         (view_mode),
        .cursor_row        (cursor_row),
        .cursor_col        (cursor_col)
    );

    always #5 clock = ~clock;

    // Count clear/start pulse cycles independently of the sequencing tasks
    always @(negedge clock) begin
        if (grid_clear === 1'b1) clr_cnt <= clr_cnt + 1;
        if (grid_start === 1'b1) st_cnt  <= st_cnt + 1;
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; start_req = 0; snap_req = 0; view_req = 0;
        gs = 0; gf = 0; gr = 4'd0; gc = 4'd0;
        #2;
        repeat (2) tick;
        n_tests++;
        if ({grid_clear, grid_start, busy, done_success, done_failure, done_timeout} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 000000",
                     {grid_clear, grid_start, busy, done_success, done_failure, done_timeout});
        end
        n_tests++;
        if ({cycles, view_mode, cursor_row, cursor_col} !== '0) begin
            n_fail++;
            $display("FAIL reset_status: got cycles=%0d view=%0d row=%0d col=%0d expected all 0",
                     cycles, view_mode, cursor_row, cursor_col);
        end
        reset = 1'b0;
        model_view = 0; model_row = 0; model_col = 0;
        repeat (2) tick;
    endtask

    // Press start from an idle/done state and check the clear/start sequence.
    // start_req is left high; run_attempt releases it.
    task automatic do_start;
        int c0, s0;
        c0 = clr_cnt; s0 = st_cnt;
        start_req = 1'b1;
        tick;  // edge 0
        tick;  // edge 1
        n_tests++;
        if (grid_clear !== 1'b0) begin
            n_fail++; $display("FAIL start_edge1_clear: got %b expected 0", grid_clear);
        end
        tick;  // edge 2
        n_tests++;
        if ({grid_clear, grid_start, busy} !== 3'b101) begin
            n_fail++; $display("FAIL start_edge2: got clr/st/busy=%b expected 101", {grid_clear, grid_start, busy});
        end
        tick;  // edge 3
        n_tests++;
        if ({grid_clear, grid_start, busy} !== 3'b011 || cycles !== '0) begin
            n_fail++; $display("FAIL start_edge3: got clr/st/busy=%b cycles=%0d expected 011 cycles=0",
                               {grid_clear, grid_start, busy}, cycles);
        end
        tick;  // edge 4: RUN entered
        n_tests++;
        if ({grid_clear, grid_start, busy, done_success, done_failure, done_timeout} !== 6'b001000) begin
            n_fail++; $display("FAIL start_run_entry: got %b expected 001000",
                               {grid_clear, grid_start, busy, done_success, done_failure, done_timeout});
        end
        n_tests++;
        if (clr_cnt - c0 !== 1 || st_cnt - s0 !== 1) begin
            n_fail++; $display("FAIL start_pulse_count: got clear=%0d start=%0d expected 1 1", clr_cnt - c0, st_cnt - s0);
        end
    endtask

    // Run one attempt from RUN entry. Done flags (kind 0=success, 1=failure,
    // 2=both) are asserted during RUN cycle k; k > T means none before timeout.
    task automatic run_attempt(input int k, input int kind, input int rel_at, input int press2_at);
        int exp_edge, c0, s0;
        logic [CW-1:0] exp_cycles;
        logic [2:0] exp_done;
        if (k <= int'(T)) begin
            exp_edge = k; exp_cycles = CW'(k - 1);
            exp_done = (kind == 1) ? 3'b010 : 3'b100;
        end else begin
            exp_edge = T; exp_cycles = CW'(T); exp_done = 3'b001;
        end
        c0 = clr_cnt; s0 = st_cnt;
        for (int e = 1; e <= exp_edge; e++) begin
            if (e == rel_at) start_req = 1'b0;
            if (e == press2_at) start_req = 1'b1;
            if (press2_at > 0 && e == press2_at + 3) start_req = 1'b0;
            if (e == k) begin gs = (kind != 1); gf = (kind != 0); end
            tick;
            if (e < exp_edge) begin
                n_tests++;
                if ({busy, done_success, done_failure, done_timeout} !== 4'b1000 || cycles !== CW'(e)) begin
                    n_fail++; $display("FAIL run_progress: edge %0d got busy/done=%b cycles=%0d expected 1000 cycles=%0d",
                                       e, {busy, done_success, done_failure, done_timeout}, cycles, e);
                end
            end
        end
        n_tests++;
        if ({busy, done_success, done_failure, done_timeout} !== {1'b0, exp_done}) begin
            n_fail++; $display("FAIL run_result: got busy/done=%b expected 0%b",
                               {busy, done_success, done_failure, done_timeout}, exp_done);
        end
        n_tests++;
        if (cycles !== exp_cycles) begin
            n_fail++; $display("FAIL run_cycles: got %0d expected %0d", cycles, exp_cycles);
        end
        n_tests++;
        if (clr_cnt != c0 || st_cnt != s0) begin
            n_fail++; $display("FAIL run_extra_pulses: got clear=%0d start=%0d expected 0 0", clr_cnt - c0, st_cnt - s0);
        end
        start_req = 1'b0; gs = 1'b0; gf = 1'b0;
        repeat (4) tick;
        n_tests++;
        if ({busy, done_success, done_failure, done_timeout} !== {1'b0, exp_done} || cycles !== exp_cycles) begin
            n_fail++; $display("FAIL result_hold: got busy/done=%b cycles=%0d expected 0%b cycles=%0d",
                               {busy, done_success, done_failure, done_timeout}, cycles, exp_done, exp_cycles);
        end
    endtask

    task automatic test_basic;
        do_start;
        run_attempt(5, 0, 6, 0);
    endtask

    task automatic test_simultaneous;
        do_start;
        run_attempt(3, 2, 1, 0);
    endtask

    task automatic test_timeout;
        do_start;
        run_attempt(T + 3, 0, 1, 0);
        do_start;
        run_attempt(2, 1, 1, 0);
    endtask

    task automatic test_back_to_back;
        do_start;
        run_attempt(7, 1, 1, 3);
    endtask

    task automatic test_view_snap;
        int h;
        for (int i = 0; i < 10; i++) begin
            h = (i < 4) ? 0 : int'($urandom_range(0, 3));
            view_req = 1'b1;
            tick; tick;
            n_tests++;
            if (view_mode !== 2'(model_view)) begin
                n_fail++; $display("FAIL view_early: press %0d got %0d expected %0d", i, view_mode, model_view);
            end
            tick;
            model_view = (model_view + 1) % 3;
            repeat (h) tick;
            n_tests++;
            if (view_mode !== 2'(model_view)) begin
                n_fail++; $display("FAIL view_step: press %0d got %0d expected %0d", i, view_mode, model_view);
            end
            view_req = 1'b0;
            repeat (2) tick;
        end
        for (int i = 0; i < 5; i++) begin
            gr = (i == 0) ? 4'd7 : 4'($urandom_range(0, 15));
            gc = (i == 0) ? 4'd3 : 4'($urandom_range(0, 15));
            snap_req = 1'b1;
            tick; tick;
            n_tests++;
            if ({cursor_row, cursor_col} !== {model_row, model_col}) begin
                n_fail++; $display("FAIL snap_early: got %0d,%0d expected %0d,%0d", cursor_row, cursor_col, model_row, model_col);
            end
            tick;
            model_row = gr; model_col = gc;
            n_tests++;
            if ({cursor_row, cursor_col} !== {model_row, model_col}) begin
                n_fail++; $display("FAIL snap_latch: got %0d,%0d expected %0d,%0d", cursor_row, cursor_col, model_row, model_col);
            end
            gr = ~gr; gc = ~gc;
            repeat (2) tick;
            snap_req = 1'b0;
            repeat (2) tick;
            n_tests++;
            if ({cursor_row, cursor_col} !== {model_row, model_col}) begin
                n_fail++; $display("FAIL snap_hold: got %0d,%0d expected %0d,%0d", cursor_row, cursor_col, model_row, model_col);
            end
        end
    endtask

    task automatic test_random_runs;
        for (int i = 0; i < 8; i++) begin
            do_start;
            run_attempt(int'($urandom_range(1, T + 2)), int'($urandom_range(0, 2)), 1, 0);
        end
    endtask

    task automatic test_reset_mid_run;
        do_start;
        start_req = 1'b0;
        repeat (3) tick;
        @(posedge clock);
        #3 reset = 1'b1;
        #1;
        model_view = 0; model_row = 0; model_col = 0;
        n_tests++;
        if ({grid_clear, grid_start, busy, done_success, done_failure, done_timeout} !== 6'b0 ||
            {cycles, view_mode, cursor_row, cursor_col} !== '0) begin
            n_fail++; $display("FAIL reset_mid_run: got flags=%b cycles=%0d view=%0d row=%0d col=%0d expected all 0",
                               {grid_clear, grid_start, busy, done_success, done_failure, done_timeout},
                               cycles, view_mode, cursor_row, cursor_col);
        end
        tick;
        reset = 1'b0;
        repeat (2) tick;
        do_start;
        run_attempt(4, 0, 1, 0);
    endtask

    initial begin
        test_reset;
        test_basic;
        test_simultaneous;
        test_timeout;
        test_back_to_back;
        test_view_snap;
        test_random_runs;
        test_reset_mid_run;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
